// File: rtl/scr1_dp_mem_bist.sv
// scr1_dp_mem_bist: march-style self-test initiator for TCM port B.
// Sequence: write P ascending, read P / write ~P ascending, read ~P descending.
// The first mismatching read is latched and the test stops at once.
module scr1_dp_mem_bist #(
  parameter int SCR1_WIDTH  = 32,
  parameter int SCR1_SIZE   = 32'h00010000,
  parameter int SCR1_NBYTES = SCR1_WIDTH / 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [SCR1_WIDTH-1:0]         pattern,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic [$clog2(SCR1_SIZE)-1:0]  fail_addr,
  output logic [SCR1_WIDTH-1:0]         fail_data,
  output logic                          renb,
  output logic                          wenb,
  output logic [SCR1_NBYTES-1:0]        webb,
  output logic [$clog2(SCR1_SIZE)-1:0]  addrb,
  output logic [SCR1_WIDTH-1:0]         datab,
  input  logic [SCR1_WIDTH-1:0]         qb
);

  localparam int N  = SCR1_SIZE / SCR1_NBYTES;
  localparam int AW = $clog2(SCR1_SIZE);
  localparam int BW = $clog2(SCR1_NBYTES);
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
  localparam logic [IW-1:0] IDX_ZERO = '0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W0,
    ST_R0W1,
    ST_R1,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t                r_state;
  logic [IW-1:0]         r_idx;
  logic                  r_phase;      // R0W1: 0 = read cycle, 1 = write cycle
  logic [SCR1_WIDTH-1:0] r_pat;
  logic                  r_pass;
  logic [AW-1:0]         r_fail_addr;
  logic [SCR1_WIDTH-1:0] r_fail_data;
  // Compare pipeline: marks the cycle in which qb holds the previous read
  logic                  r_cmp_vld;
  logic [AW-1:0]         r_cmp_addr;
  logic [SCR1_WIDTH-1:0] r_cmp_exp;

  state_t                w_state_nxt;
  logic [IW-1:0]         w_idx_nxt;
  logic                  w_phase_nxt;
  logic [SCR1_WIDTH-1:0] w_pat_nxt;
  logic                  w_pass_nxt;
  logic [AW-1:0]         w_fail_addr_nxt;
  logic [SCR1_WIDTH-1:0] w_fail_data_nxt;
  logic                  w_ren;
  logic                  w_wen;
  logic [SCR1_WIDTH-1:0] w_wdata;
  logic                  w_mismatch;
  logic [AW-1:0]         w_req_addr;

  assign w_mismatch = r_cmp_vld && (qb != r_cmp_exp);
  assign w_req_addr = {r_idx, {BW{1'b0}}};

  // Next-state, request generation and mismatch capture
  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_phase_nxt     = r_phase;
    w_pat_nxt       = r_pat;
    w_pass_nxt      = r_pass;
    w_fail_addr_nxt = r_fail_addr;
    w_fail_data_nxt = r_fail_data;
    w_ren           = 1'b0;
    w_wen           = 1'b0;
    w_wdata         = '0;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt     = ST_W0;
          w_idx_nxt       = '0;
          w_phase_nxt     = 1'b0;
          w_pat_nxt       = pattern;
          w_pass_nxt      = 1'b0;
          w_fail_addr_nxt = '0;
          w_fail_data_nxt = '0;
        end
      end
      ST_W0: begin
        w_wen   = 1'b1;
        w_wdata = r_pat;
        if (r_idx == IDX_LAST) begin
          w_state_nxt = ST_R0W1;
          w_idx_nxt   = '0;
          w_phase_nxt = 1'b0;
        end else begin
          w_idx_nxt = r_idx + IW'(1);
        end
      end
      ST_R0W1: begin
        if (!r_phase) begin
          w_ren       = 1'b1;
          w_phase_nxt = 1'b1;
        end else begin
          w_wen       = 1'b1;
          w_wdata     = ~r_pat;
          w_phase_nxt = 1'b0;
          if (r_idx == IDX_LAST) begin
            w_state_nxt = ST_R1;
            w_idx_nxt   = IDX_LAST;
          end else begin
            w_idx_nxt = r_idx + IW'(1);
          end
        end
      end
      ST_R1: begin
        w_ren = 1'b1;
        if (r_idx == IDX_ZERO) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_idx_nxt = r_idx - IW'(1);
        end
      end
      ST_DRAIN: begin
        w_state_nxt = ST_DONE;
        w_pass_nxt  = 1'b1;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // A mismatch overrides everything: abandon the stream and report
    if (w_mismatch) begin
      w_state_nxt     = ST_DONE;
      w_pass_nxt      = 1'b0;
      w_fail_addr_nxt = r_cmp_addr;
      w_fail_data_nxt = qb;
    end
  end

  // State, counters, result and compare-pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_phase     <= 1'b0;
      r_pat       <= '0;
      r_pass      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_data <= '0;
      r_cmp_vld   <= 1'b0;
      r_cmp_addr  <= '0;
      r_cmp_exp   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_phase     <= w_phase_nxt;
      r_pat       <= w_pat_nxt;
      r_pass      <= w_pass_nxt;
      r_fail_addr <= w_fail_addr_nxt;
      r_fail_data <= w_fail_data_nxt;
      r_cmp_vld   <= w_ren && !w_mismatch;
      r_cmp_addr  <= w_req_addr;
      r_cmp_exp   <= (r_state == ST_R0W1) ? r_pat : ~r_pat;
    end
  end

  assign busy      = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign done      = (r_state == ST_DONE);
  assign pass      = r_pass;
  assign fail_addr = r_fail_addr;
  assign fail_data = r_fail_data;
  assign renb      = w_ren;
  assign wenb      = w_wen;
  assign webb      = {SCR1_NBYTES{w_wen}};
  assign addrb     = (w_ren || w_wen) ? w_req_addr : '0;
  assign datab     = w_wdata;

endmodule

// File: tb/tb_scr1_dp_mem_bist.sv
// tb_scr1_dp_mem_bist: directed + randomized runs against a march-level model
// of the expected request stream, with a fault-injecting memory on port B.
module tb_scr1_dp_mem_bist;

  localparam int NW = 16;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] pattern;
  logic        busy, done, pass, renb, wenb;
  logic [5:0]  fail_addr, addrb;
  logic [31:0] fail_data, datab, qb;
  logic [3:0]  webb;

  logic [31:0] mem [NW];
  logic [31:0] sa0 [NW];
  logic [31:0] sa1 [NW];

  int n_chk;
  int n_pass;

  scr1_dp_mem_bist #(
    .SCR1_WIDTH (32),
    .SCR1_SIZE  (64)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .pattern   (pattern),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_addr (fail_addr),
    .fail_data (fail_data),
    .renb      (renb),
    .wenb      (wenb),
    .webb      (webb),
    .addrb     (addrb),
    .datab     (datab),
    .qb        (qb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Port B memory with one-cycle read latency and stuck-at faults on read
  always @(posedge clk) begin
    if (wenb) begin
      for (int b = 0; b < 4; b++)
        if (webb[b]) mem[addrb[5:2]][8*b +: 8] <= datab[8*b +: 8];
    end
    if (renb) qb <= (mem[addrb[5:2]] & ~sa0[addrb[5:2]]) | sa1[addrb[5:2]];
  end

  function automatic logic [84:0] pack(input logic b, input logic d, input logic p,
                                       input logic r, input logic w, input logic [3:0] be,
                                       input logic [5:0] a, input logic [31:0] dat,
                                       input logic [5:0] fa, input logic [31:0] fd);
    return {b, d, p, r, w, be, a, dat, fa, fd};
  endfunction

  function automatic logic [84:0] observed();
    return pack(busy, done, pass, renb, wenb, webb, addrb, datab, fail_addr, fail_data);
  endfunction

  task automatic check(input string tag, input logic [84:0] obs, input logic [84:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic clear_faults();
    for (int w = 0; w < NW; w++) begin
      sa0[w] = '0;
      sa1[w] = '0;
    end
  endtask

  // One test: model the march, start the DUT, compare every cycle, then the result
  task automatic run(input string name, input logic [31:0] p, input int pulse_at,
                     input int abort_at);
    logic        o_ren [65];
    logic        o_wen [65];
    logic [5:0]  o_addr [65];
    logic [31:0] o_data [65];
    logic [31:0] o_exp [65];
    logic [31:0] m [NW];
    logic [31:0] v;
    int          len;
    logic        det;
    logic [5:0]  efa;
    logic [31:0] efd;

    for (int t = 0; t < 65; t++) begin
      o_ren[t] = 0; o_wen[t] = 0; o_addr[t] = '0; o_data[t] = '0; o_exp[t] = '0;
    end
    for (int w = 0; w < NW; w++) begin
      o_wen[w] = 1; o_addr[w] = 6'(w * 4); o_data[w] = p;
      o_ren[16 + 2*w] = 1; o_addr[16 + 2*w] = 6'(w * 4); o_exp[16 + 2*w] = p;
      o_wen[17 + 2*w] = 1; o_addr[17 + 2*w] = 6'(w * 4); o_data[17 + 2*w] = ~p;
      o_ren[48 + w] = 1; o_addr[48 + w] = 6'((15 - w) * 4); o_exp[48 + w] = ~p;
    end

    // Play the stream against an ideal memory with the faults applied on read
    det = 0; len = 65; efa = '0; efd = '0;
    for (int t = 0; t < 65 && !det; t++) begin
      if (o_wen[t]) m[o_addr[t][5:2]] = o_data[t];
      if (o_ren[t]) begin
        v = (m[o_addr[t][5:2]] & ~sa0[o_addr[t][5:2]]) | sa1[o_addr[t][5:2]];
        if (v !== o_exp[t]) begin
          det = 1; len = t + 2; efa = o_addr[t]; efd = v;
        end
      end
    end

    @(negedge clk);
    pattern = p;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    for (int i = 0; i < len; i++) begin
      check($sformatf("%s cyc%0d", name, i), observed(),
            pack(1'b1, 1'b0, 1'b0, o_ren[i], o_wen[i], {4{o_wen[i]}},
                 o_addr[i], o_wen[i] ? o_data[i] : 32'h0, 6'h0, 32'h0));
      if (i == abort_at) begin
        rst_n = 1'b0;
        #1;
        check($sformatf("%s async_reset", name), observed(), 85'h0);
        @(negedge clk);
        check($sformatf("%s in_reset", name), observed(), 85'h0);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          check($sformatf("%s idle%0d", name, k), observed(), 85'h0);
        end
        $display("run %s pattern=%h aborted at cycle %0d", name, p, i);
        return;
      end
      start   = (i == pulse_at);
      pattern = (i == pulse_at) ? ~p : p;
      @(negedge clk);
    end
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s result%0d", name, k), observed(),
            pack(1'b0, 1'b1, !det, 1'b0, 1'b0, 4'h0, 6'h0, 32'h0, efa, efd));
      @(negedge clk);
    end
    $display("run %s pattern=%h cycles=%0d detect=%0d fail_addr=%h fail_data=%h",
             name, p, len, det, fail_addr, fail_data);
  endtask

  initial begin
    logic [31:0] rp;
    int          rw;
    int          rb;
    n_chk   = 0;
    n_pass  = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    pattern = '0;
    for (int w = 0; w < NW; w++) mem[w] = '0;
    clear_faults();

    // Reset state, then ten idle cycles with no request
    repeat (3) @(negedge clk);
    check("reset_hold", observed(), 85'h0);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("post_reset_idle%0d", k), observed(), 85'h0);
    end

    run("clean_a5", 32'hA5A5_5A5A, -1, -1);

    sa0[5] = 32'h0000_0008;
    run("w5b3_sa0", 32'hFFFF_FFFF, -1, -1);
    check32("w5b3_fail_addr", {26'h0, fail_addr}, 32'h14);
    check32("w5b3_fail_data", fail_data, 32'hFFFF_FFF7);

    clear_faults();
    run("restart_clean", 32'hA5A5_5A5A, -1, -1);

    sa1[15] = 32'h0000_0001;
    run("w15b0_sa1", 32'h0000_0001, -1, -1);
    check32("w15b0_fail_addr", {26'h0, fail_addr}, 32'h3C);
    check32("w15b0_fail_data", fail_data, 32'hFFFF_FFFF);
    check32("w15b0_pass", {31'h0, pass}, 32'h0);
    clear_faults();

    run("start_ignored", 32'h1234_5678, 10, -1);
    run("reset_midrun", 32'h0F0F_F0F0, -1, 20);

    for (int r = 0; r < 3; r++) begin
      rp = $urandom;
      run($sformatf("rand_clean%0d", r), rp, -1, -1);
    end
    for (int r = 0; r < 4; r++) begin
      rp = $urandom;
      rw = $urandom_range(NW - 1);
      rb = $urandom_range(31);
      clear_faults();
      if ($urandom_range(1) == 0) sa0[rw][rb] = 1'b1;
      else sa1[rw][rb] = 1'b1;
      run($sformatf("rand_fault%0d_w%0d_b%0d", r, rw, rb), rp, -1, -1);
    end
    clear_faults();
    run("final_clean", 32'hDEAD_BEEF, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Safety bound in case the bench itself stalls
  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/scr1_dp_mem_bist.md
# scr1_dp_mem_bist

Built-in self-test initiator for the dual-port TCM memory. It drives the memory's port B read/write request interface: it writes a pattern, reads it back, writes the complement, then reads that back. It compares every returned word and reports pass/fail with the first failing address and data. It sits between the TCM wrapper and the memory, and owns port B only while a test runs.

## Interface
Parameters:
- SCR1_WIDTH, 32, memory word width in bits
- SCR1_SIZE, `SCR1_IMEM_AWIDTH'h00010000, memory size in bytes
- SCR1_NBYTES, SCR1_WIDTH/8, bytes per word

Ports (one clock `clk`; reset `rst_n` is asynchronous, active-low):
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  start request; sampled only in IDLE or DONE
- pattern  input  SCR1_WIDTH  test pattern; captured when start is accepted
- busy  output  1  test in progress
- done  output  1  test finished; held until next accepted start
- pass  output  1  valid while done=1; 1 = no mismatch
- fail_addr  output  $clog2(SCR1_SIZE)  byte address of first mismatch
- fail_data  output  SCR1_WIDTH  qb value at first mismatch
- renb  output  1  port B read enable
- wenb  output  1  port B write enable
- webb  output  SCR1_NBYTES  byte enables; all ones when wenb=1, else zero
- addrb  output  $clog2(SCR1_SIZE)  byte address; word-aligned, low $clog2(SCR1_NBYTES) bits always 0
- datab  output  SCR1_WIDTH  write data; 0 when wenb=0
- qb  input  SCR1_WIDTH  read data; valid the cycle after renb=1

## Operation
- N = SCR1_SIZE/SCR1_NBYTES words. Word index counter is $clog2(N) bits wide. addrb = {idx, zeros}.
- On start in IDLE/DONE: capture pattern as P, clear done/pass/fail_*, go to W0 with idx=0.
- States:
  - IDLE: no request.
  - W0: ascending; each cycle wenb=1, datab=P, idx++. After idx=N-1, go to R0W1 with idx=0.
  - R0W1: ascending, two cycles per word.
    - Cycle a: renb=1.
    - Cycle b: wenb=1, datab=~P, and compare qb against P. On idx=N-1 in cycle b, go to R1 with idx=N-1.
  - R1: descending; each cycle renb=1. The compare of the previous read (expected ~P) happens in the same cycle. After idx=0, go to DRAIN.
  - DRAIN: no request; compare the last R1 read.
  - DONE: no request; done=1, busy=0.
- Compare pipeline: a registered flag and address mark the cycle in which qb must be checked.
- First mismatch: latch fail_addr (address of that read) and fail_data=qb, set pass=0, and go straight to DONE. The outstanding request stream is abandoned, and no further port B request is issued.
- No mismatch through DRAIN: pass=1 in DONE.
- renb and wenb are never both 1 in the same cycle.
- start while busy=1 is ignored.

## Timing
- Reset values: busy=0, done=0, pass=0, fail_addr=0, fail_data=0, renb=0, wenb=0, webb=0, addrb=0, datab=0; state IDLE.
- Start accepted at edge k:
  - First W0 request and busy=1 appear in cycle k+1.
  - A clean run keeps busy=1 for exactly 4N+1 cycles (W0 N, R0W1 2N, R1 N, DRAIN 1).
  - done=1 in the following cycle.
- A failure detected in cycle c gives done=1 and busy=0 in cycle c+1.
- Mid-test reset: all outputs return to reset values immediately; memory contents are undefined afterwards.
- Start in DONE restarts with the same latency as from IDLE.
- idx wrap is not used. Terminal conditions compare against N-1 or 0 explicitly.

## Test plan
Benches use SCR1_SIZE=64 (N=16) with a behavioural memory model on port B (one-cycle read latency).
- Reset: hold rst_n=0, then release -> all outputs 0, no request for 10 idle cycles.
- Clean run, pattern=32'hA5A5_5A5A -> busy for 65 cycles, then done=1, pass=1. W0 addrb 0x00..0x3C step 4 with datab A5A55A5A. R0W1 writes 5A5AA5A5. R1 addrb 0x3C down to 0x00. Never renb&wenb.
- Word 5 bit 3 stuck-at-0, pattern=32'hFFFF_FFFF -> mismatch in R0W1, done=1, pass=0, fail_addr=0x14, fail_data=32'hFFFF_FFF7, no request after detection.
- Word 15 bit 0 stuck-at-1, pattern=32'h0000_0001 -> R0W1 clean, mismatch on first R1 read, fail_addr=0x3C, fail_data=32'hFFFF_FFFF, pass=0.
- Start pulsed at cycle 10 of a run -> ignored, run length still 65. Then rst_n=0 at cycle 20 -> outputs reset asynchronously, state IDLE.
- Start re-asserted in DONE after a failing run, fault removed -> done/pass/fail_* cleared in the next cycle, new run completes with pass=1.
